additive_voice: RTL and testbench

Time-multiplexed additive oscillator for the audio path. It sums four harmonic sine bins from the shared 256-entry sine LUT and delivers one 16-bit unsigned sample per I2S frame to the PCM5102 DAC stage. The block sits directly upstream of the DAC and is paced by that stage's `lrck` output. It replaces the free-running adder with a frame-synchronous, gain-controlled, handshaked producer.

---
 rtl/addvoice_pkg.sv | 27 ++
 rtl/additive_phase_bank.sv | 48 ++++
 rtl/additive_voice.sv | 161 ++++++++++++++++
 tb/tb_additive_voice.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/addvoice_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | addvoice_pkg                                                          |
// | Shared types, widths and reset gains for the additive voice.          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package addvoice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int ACC_W  = 22;
  localparam int GAIN_W = 4;

  // Reset gains halve per harmonic: {8,4,2,1}, zero beyond bin 3.
  localparam logic [GAIN_W-1:0] c_gain_rst_top = 4'd8;

  function automatic logic [GAIN_W-1:0] reset_gain(input int k);
    return c_gain_rst_top >> k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/additive_phase_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | additive_phase_bank                                                   |
// | Per-bin phase accumulators with harmonic increments and read mux.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module additive_phase_bank #(
  parameter int NUM_BINS = 4,
  parameter int PHASE_W  = 24,
  parameter int LUT_AW   = 8,
  parameter int BIN_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               upd_en,
  input  logic [BIN_W-1:0]   upd_sel,
  input  logic [BIN_W-1:0]   rd_sel,
  output logic [LUT_AW-1:0]  rd_addr
);

  logic [PHASE_W-1:0] r_phase [NUM_BINS];
  logic [PHASE_W-1:0] w_inc   [NUM_BINS];

  // (k+1)*tune_word as a sum of shifted copies, one per set bit of k+1.
  always_comb begin
    for (int k = 0; k < NUM_BINS; k++) begin
      w_inc[k] = '0;
      for (int j = 0; j < 8; j++) begin
        if ((((k + 1) >> j) & 1) != 0) w_inc[k] = w_inc[k] + (tune_word << j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BINS; k++) r_phase[k] <= '0;
    end else if (upd_en) begin
      for (int k = 0; k < NUM_BINS; k++) begin
        if (upd_sel == BIN_W'(k)) r_phase[k] <= r_phase[k] + w_inc[k];
      end
    end
  end

  assign rd_addr = r_phase[rd_sel][PHASE_W-1 -: LUT_AW];

endmodule
`default_nettype wire

// File: rtl/additive_voice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | additive_voice                                                        |
// | Frame-synchronous four-bin additive oscillator feeding the I2S DAC.   |
// | Optional saturation/clip detect: define ADDVOICE_SAT_EN.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module additive_voice
  import addvoice_pkg::*;
#(
  parameter int NUM_BINS   = 4,
  parameter int PHASE_W    = 24,
  parameter int LUT_AW     = 8,
  parameter int GAIN_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lrck,
  input  logic [PHASE_W-1:0] tune_word,
  input  logic               gain_we,
  input  logic [1:0]         gain_sel,
  input  logic [3:0]         gain_data,
  output logic [LUT_AW-1:0]  lut_addr,
  input  logic [15:0]        lut_data,
  output logic [15:0]        sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun,
  output logic               clip
);

  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  state_t              r_state, w_state_nxt;
  logic                r_lrck_q;
  logic                w_req;
  logic [BIN_W-1:0]    r_bin, w_addr_sel;
  logic                w_last, w_load_addr, w_phase_upd;
  logic [PHASE_W-1:0]  r_tune_sh;
  logic [GAIN_W-1:0]   r_gain    [NUM_BINS];
  logic [GAIN_W-1:0]   r_gain_sh [NUM_BINS];
  logic [ACC_W-1:0]    r_acc;
  logic [19:0]         w_prod;
  logic [LUT_AW-1:0]   w_rd_addr;
  logic [LUT_AW-1:0]   r_lut_addr;
  logic [15:0]         r_sample, w_sample_nxt;
  logic                r_valid, r_overrun;

  assign w_req  = lrck & ~r_lrck_q;
  assign w_last = (r_bin == BIN_W'(NUM_BINS - 1));
  assign w_prod = 20'(lut_data) * 20'(r_gain_sh[r_bin]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = ST_ADDR;
      ST_ADDR: w_state_nxt = ST_DATA;
      ST_DATA: w_state_nxt = w_last ? ST_DONE : ST_ADDR;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The LUT address is registered on entry to ADDR so the data lands in DATA.
  always_comb begin
    busy        = (r_state != ST_IDLE);
    w_phase_upd = (r_state == ST_DATA);
    w_load_addr = ((r_state == ST_IDLE) && w_req) || ((r_state == ST_DATA) && !w_last);
    w_addr_sel  = (r_state == ST_IDLE) ? '0 : r_bin + 1'b1;
  end

  additive_phase_bank #(
    .NUM_BINS (NUM_BINS),
    .PHASE_W  (PHASE_W),
    .LUT_AW   (LUT_AW),
    .BIN_W    (BIN_W)
  ) u_phase_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .tune_word (r_tune_sh),
    .upd_en    (w_phase_upd),
    .upd_sel   (r_bin),
    .rd_sel    (w_addr_sel),
    .rd_addr   (w_rd_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_BINS; k++) r_gain[k] <= reset_gain(k);
    end else if (gain_we) begin
      for (int k = 0; k < NUM_BINS; k++) begin
        if (gain_sel == 2'(k)) r_gain[k] <= gain_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lrck_q   <= 1'b0;
      r_tune_sh  <= '0;
      for (int k = 0; k < NUM_BINS; k++) r_gain_sh[k] <= reset_gain(k);
      r_acc      <= '0;
      r_bin      <= '0;
      r_lut_addr <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_lrck_q <= lrck;
      r_valid  <= 1'b0;
      if (w_req && busy) r_overrun <= 1'b1;
      if ((r_state == ST_IDLE) && w_req) begin
        r_tune_sh <= tune_word;
        r_gain_sh <= r_gain;
        r_acc     <= '0;
        r_bin     <= '0;
      end
      if (w_load_addr) r_lut_addr <= w_rd_addr;
      if (r_state == ST_DATA) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        if (!w_last) r_bin <= r_bin + 1'b1;
      end
      if (r_state == ST_DONE) begin
        r_sample <= w_sample_nxt;
        r_valid  <= 1'b1;
      end
    end
  end

`ifdef ADDVOICE_SAT_EN
  logic [ACC_W-1:0] w_shifted;
  logic             w_over;
  logic             r_clip;

  assign w_shifted    = r_acc >> GAIN_SHIFT;
  assign w_over       = |w_shifted[ACC_W-1:16];
  assign w_sample_nxt = w_over ? 16'hFFFF : w_shifted[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           r_clip <= 1'b0;
    else if ((r_state == ST_DONE) && w_over) r_clip <= 1'b1;
  end

  assign clip = r_clip;
`else
  assign w_sample_nxt = 16'(r_acc >> GAIN_SHIFT);
  assign clip         = 1'b0;
`endif

  assign lut_addr     = r_lut_addr;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_additive_voice.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_additive_voice                                                     |
// | Directed self-checking bench for additive_voice.                      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_additive_voice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lrck = 1'b0;
  logic [23:0] tune_word = '0;
  logic        gain_we = 1'b0;
  logic [1:0]  gain_sel = '0;
  logic [3:0]  gain_data = '0;
  logic [7:0]  lut_addr;
  logic [15:0] lut_data = '0;
  logic [15:0] sample_out;
  logic        sample_valid, busy, overrun, clip;

  logic [15:0] lut_fill = 16'h0000;
  logic [7:0]  addr_cap [4];
  logic        busy_cap [21];
  int          n_cmp = 0;
  int          n_bad = 0;

  additive_voice dut (
    .clk(clk), .rst_n(rst_n), .lrck(lrck), .tune_word(tune_word),
    .gain_we(gain_we), .gain_sel(gain_sel), .gain_data(gain_data),
    .lut_addr(lut_addr), .lut_data(lut_data), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun), .clip(clip)
  );

  always #5 clk = ~clk;

  // Synchronous LUT model: one cycle of read latency.
  always @(posedge clk) lut_data <= lut_fill;

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_gain(input logic [1:0] sel, input logic [3:0] val);
    @(negedge clk);
    gain_we = 1'b1; gain_sel = sel; gain_data = val;
    @(negedge clk);
    gain_we = 1'b0;
  endtask

  // Raise lrck, then observe intervals 1..20 after the detecting edge.
  task automatic run_frame(input int wr_at, input logic [1:0] wsel, input logic [3:0] wval,
                           output int vcyc, output logic [15:0] smp, output int nvalid);
    vcyc = -1; smp = '0; nvalid = 0;
    @(negedge clk);
    lrck = 1'b1;
    if (wr_at == 0) begin gain_we = 1'b1; gain_sel = wsel; gain_data = wval; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      busy_cap[i] = busy;
      if (i % 2 == 1 && i <= 7) addr_cap[i/2] = lut_addr;
      if (sample_valid) begin
        nvalid++;
        if (vcyc < 0) begin vcyc = i; smp = sample_out; end
      end
      gain_we = 1'b0;
      if (i == 1) lrck = 1'b0;
      if (i == wr_at) begin gain_we = 1'b1; gain_sel = wsel; gain_data = wval; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (lut_addr !== 8'h00)      begin n_bad++; $display("FAIL reset_lut_addr got %h want 00", lut_addr); end
    n_cmp++; if (sample_out !== 16'h0000) begin n_bad++; $display("FAIL reset_sample got %h want 0000", sample_out); end
    n_cmp++; if ({sample_valid, busy, overrun, clip} !== 4'b0000)
      begin n_bad++; $display("FAIL reset_flags got %b want 0000", {sample_valid, busy, overrun, clip}); end
  endtask

  task automatic test_reset_mix();
    int vc, nv; logic [15:0] s;
    lut_fill = 16'h8000; tune_word = '0;
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
    n_cmp++; if (vc !== 10)       begin n_bad++; $display("FAIL mix_valid_cycle got %0d want 10", vc); end
    n_cmp++; if (s !== 16'h7800)  begin n_bad++; $display("FAIL mix_sample got %h want 7800", s); end
    n_cmp++; if (nv !== 1)        begin n_bad++; $display("FAIL mix_valid_count got %0d want 1", nv); end
    n_cmp++; if (clip !== 1'b0)   begin n_bad++; $display("FAIL mix_clip got %b want 0", clip); end
    n_cmp++; if ({busy_cap[1], busy_cap[9], busy_cap[10]} !== 3'b110)
      begin n_bad++; $display("FAIL mix_busy got %b want 110", {busy_cap[1], busy_cap[9], busy_cap[10]}); end
  endtask

  task automatic test_saturation();
    int vc, nv; logic [15:0] s;
    do_reset();
    for (int k = 0; k < 4; k++) write_gain(2'(k), 4'd15);
    lut_fill = 16'hFFFF;
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
`ifdef ADDVOICE_SAT_EN
    n_cmp++; if (s !== 16'hFFFF) begin n_bad++; $display("FAIL sat_sample got %h want ffff", s); end
    n_cmp++; if (clip !== 1'b1)  begin n_bad++; $display("FAIL sat_clip got %b want 1", clip); end
`else
    n_cmp++; if (s !== 16'hBFFC) begin n_bad++; $display("FAIL wrap_sample got %h want bffc", s); end
    n_cmp++; if (clip !== 1'b0)  begin n_bad++; $display("FAIL wrap_clip got %b want 0", clip); end
`endif
  endtask

  task automatic test_phase_step();
    int vc, nv; logic [15:0] s;
    do_reset();
    lut_fill = 16'h0000; tune_word = 24'h010000;
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (addr_cap[k] !== 8'h00)
        begin n_bad++; $display("FAIL phase_f1_bin%0d got %h want 00", k, addr_cap[k]); end
    end
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (addr_cap[k] !== 8'(k + 1))
        begin n_bad++; $display("FAIL phase_f2_bin%0d got %h want %h", k, addr_cap[k], 8'(k + 1)); end
    end
  endtask

  task automatic test_overrun();
    int nv, vc;
    do_reset();
    lut_fill = 16'h8000; tune_word = '0; nv = 0; vc = -1;
    @(negedge clk);
    lrck = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (sample_valid) begin nv++; if (vc < 0) vc = i; end
      if (i == 1) lrck = 1'b0;
      if (i == 5) lrck = 1'b1;
      if (i == 6) lrck = 1'b0;
    end
    n_cmp++; if (nv !== 1)         begin n_bad++; $display("FAIL ovr_valid_count got %0d want 1", nv); end
    n_cmp++; if (vc !== 10)        begin n_bad++; $display("FAIL ovr_valid_cycle got %0d want 10", vc); end
    n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", overrun); end
    do_reset();
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_cleared got %b want 0", overrun); end
  endtask

  task automatic test_gain_mid();
    int vc, nv; logic [15:0] s;
    do_reset();
    lut_fill = 16'h1000; tune_word = '0;
    run_frame(3, 2'd0, 4'd0, vc, s, nv);
    n_cmp++; if (s !== 16'h0F00) begin n_bad++; $display("FAIL gmid_cur got %h want 0f00", s); end
    // Write gain[1]=0 in the same cycle as the frame start: shadow keeps 4.
    run_frame(0, 2'd1, 4'd0, vc, s, nv);
    n_cmp++; if (s !== 16'h0700) begin n_bad++; $display("FAIL gmid_next got %h want 0700", s); end
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
    n_cmp++; if (s !== 16'h0300) begin n_bad++; $display("FAIL gsim_next got %h want 0300", s); end
  endtask

  task automatic test_reset_mid();
    int vc, nv; logic [15:0] s;
    do_reset();
    lut_fill = 16'h8000; tune_word = 24'h010000;
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
    @(negedge clk);
    lrck = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) lrck = 1'b0;
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({sample_valid, busy, overrun, clip} !== 4'b0000)
      begin n_bad++; $display("FAIL rmid_flags got %b want 0000", {sample_valid, busy, overrun, clip}); end
    n_cmp++; if ({lut_addr, sample_out} !== 24'h000000)
      begin n_bad++; $display("FAIL rmid_data got %h want 000000", {lut_addr, sample_out}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (15) begin @(negedge clk); if (sample_valid) nv++; end
    n_cmp++; if (nv !== 0) begin n_bad++; $display("FAIL rmid_no_valid got %0d want 0", nv); end
    run_frame(-1, 2'd0, 4'd0, vc, s, nv);
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (addr_cap[k] !== 8'h00)
        begin n_bad++; $display("FAIL rmid_phase_bin%0d got %h want 00", k, addr_cap[k]); end
    end
    n_cmp++; if (s !== 16'h7800) begin n_bad++; $display("FAIL rmid_sample got %h want 7800", s); end
  endtask

  initial begin
    test_reset();
    test_reset_mix();
    test_saturation();
    test_phase_step();
    test_overrun();
    test_gain_mid();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
